// File: rtl/ripemd_block_feeder.sv
// Byte-stream front end for the RIPEMD-160 core: builds the single padded block,
// hands it to the core and returns the captured digest on a valid/ready port.
module ripemd_block_feeder #(
   parameter int unsigned MAX_BYTES    = 55,
   parameter int unsigned CORE_TIMEOUT = 1024
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         s_valid_i,
   input  logic [7:0]   s_data_i,
   input  logic         s_keep_i,
   input  logic         s_last_i,
   output logic         s_ready_o,
   output logic [511:0] block_o,
   output logic         i_valid_o,
   input  logic         o_valid_i,
   input  logic [159:0] ans_i,
   output logic [159:0] digest_o,
   output logic         d_valid_o,
   input  logic         d_ready_i,
   output logic         err_len_o,
   output logic         err_timeout_o
);

   localparam int unsigned     TimerW     = (CORE_TIMEOUT < 2) ? 1 : $clog2(CORE_TIMEOUT + 1);
   localparam logic [TimerW-1:0] TimeoutVal = TimerW'(CORE_TIMEOUT);
   localparam logic [5:0]      MaxLen     = 6'(MAX_BYTES);

   typedef enum logic [2:0] {StIdle, StLoad, StDrain, StPad, StIssue, StOut} state_e;

   state_e              state_q, state_d;
   logic [511:0]        block_q, block_d;
   logic [159:0]        digest_q, digest_d;
   logic [5:0]          len_q, len_d, cur_len;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic                o_valid_prev_q;
   logic                o_valid_rise;
   logic [8:0]          bit_len;

   assign o_valid_rise = o_valid_i & ~o_valid_prev_q;
   assign bit_len      = {len_q, 3'b000};
   assign block_o      = block_q;
   assign digest_o     = digest_q;

   always_comb begin
      state_d       = state_q;
      block_d       = block_q;
      digest_d      = digest_q;
      len_d         = len_q;
      timer_d       = timer_q;
      cur_len       = len_q;
      s_ready_o     = 1'b0;
      i_valid_o     = 1'b0;
      d_valid_o     = 1'b0;
      err_len_o     = 1'b0;
      err_timeout_o = 1'b0;

      unique case (state_q)
         StIdle, StLoad: begin
            s_ready_o = 1'b1;
            if (s_valid_i) begin
               // The first beat of a message starts from a clean block.
               if (state_q == StIdle) begin
                  block_d = '0;
                  cur_len = '0;
               end
               len_d   = cur_len;
               state_d = StLoad;
               if (s_keep_i) begin
                  if (cur_len == MaxLen) begin
                     err_len_o = 1'b1;
                     state_d   = s_last_i ? StIdle : StDrain;
                  end else begin
                     block_d[511 - 8*int'(cur_len) -: 8] = s_data_i;
                     len_d = cur_len + 6'd1;
                     if (s_last_i) state_d = StPad;
                  end
               end else if (s_last_i) begin
                  state_d = StPad;
               end
            end
         end
         StDrain: begin
            s_ready_o = 1'b1;
            if (s_valid_i && s_last_i) state_d = StIdle;
         end
         StPad: begin
            // Length field is little-endian, so its LSB lands in byte 56.
            block_d[511 - 8*int'(len_q) -: 8] = 8'h80;
            block_d[63:56] = bit_len[7:0];
            block_d[55:48] = {7'b0, bit_len[8]};
            timer_d        = '0;
            state_d        = StIssue;
         end
         StIssue: begin
            i_valid_o = 1'b1;
            if (o_valid_rise) begin
               digest_d = ans_i;
               state_d  = StOut;
            end else if (CORE_TIMEOUT != 0 && timer_q == TimeoutVal) begin
               err_timeout_o = 1'b1;
               state_d       = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StOut: begin
            d_valid_o = 1'b1;
            if (d_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         block_q        <= '0;
         digest_q       <= '0;
         len_q          <= '0;
         timer_q        <= '0;
         o_valid_prev_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         block_q        <= block_d;
         digest_q       <= digest_d;
         len_q          <= len_d;
         timer_q        <= timer_d;
         o_valid_prev_q <= o_valid_i;
      end
   end

endmodule
